// File: rtl/knight_cmd_link_if.sv
`timescale 1ns/1ps
// knight_cmd_link_if: serial lines plus command/response handshake of the command link
interface knight_cmd_link_if;
  logic RX;
  logic TX;
  logic [15:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic [7:0] resp;
  logic send_resp;
  logic tx_busy;
  logic resp_sent;
  logic frm_err;
  modport master (output RX, clr_cmd_rdy, resp, send_resp,
                  input TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err);
  modport slave (input RX, clr_cmd_rdy, resp, send_resp,
                 output TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err);
endinterface

// File: rtl/knight_cmd_link.sv
`timescale 1ns/1ps
// knight_cmd_link: UART receiver assembling 16-bit commands plus single-byte response transmitter
module knight_cmd_link #(
  parameter int BAUD_DIV = 2604,
  parameter logic [31:0] BYTE_TMO = 32'd2_000_000
) (
  input logic clk,
  input logic rst,
  knight_cmd_link_if.slave bus
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BIT_END = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} pair_state_t;
  typedef enum logic {T_IDLE, T_BUSY} tx_state_t;

  rx_state_t rx_st, rx_nx;
  pair_state_t pair_st, pair_nx;
  tx_state_t tx_st, tx_nx;

  logic rx_ff1, rx_s, rx_prev, rx_vld1, rx_vld2, armed;
  logic [BW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit;
  logic [3:0] tx_bit;
  logic [7:0] rx_sh, hi;
  logic [8:0] tx_sh;
  logic [31:0] tmo_cnt;
  logic start, rx_tick, byte_ok, byte_bad, tmo, tx_tick, tx_done;

  // armed only after a real synchronized 1, so a line already low out of reset is not a start
  always_ff @(posedge clk)
    if (rst) {rx_ff1, rx_s, rx_prev, rx_vld1, rx_vld2, armed} <= 6'b111000;
    else {rx_ff1, rx_s, rx_prev, rx_vld1, rx_vld2, armed} <=
      {bus.RX, rx_ff1, rx_s, 1'b1, rx_vld1, armed | (rx_vld2 & rx_s)};

  assign start = rx_st == R_IDLE && armed && rx_prev && !rx_s;
  assign rx_tick = rx_cnt == (rx_st == R_START ? HALF_END : BIT_END);
  assign byte_ok = rx_st == R_STOP && rx_tick && rx_s;
  assign byte_bad = rx_st == R_STOP && rx_tick && !rx_s;

  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      R_IDLE: if (start) rx_nx = R_START;
      R_START: if (rx_tick) rx_nx = rx_s ? R_IDLE : R_DATA;
      R_DATA: if (rx_tick && rx_bit == 3'd7) rx_nx = R_STOP;
      default: if (rx_tick) rx_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_st <= rx_nx;
      rx_cnt <= (rx_st == R_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_st == R_DATA && rx_tick) begin
        rx_sh <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
    end

  // the low-byte timeout only runs while the receiver is idle waiting for a start edge
  assign tmo = pair_st == WAIT_LO && rx_st == R_IDLE && !start && tmo_cnt == BYTE_TMO - 32'd1;

  always_comb pair_nx = (byte_bad || tmo) ? WAIT_HI :
                        byte_ok ? (pair_st == WAIT_HI ? WAIT_LO : WAIT_HI) : pair_st;

  always_ff @(posedge clk)
    if (rst) begin
      pair_st <= WAIT_HI;
      hi <= '0;
      tmo_cnt <= '0;
      bus.cmd <= '0;
      bus.cmd_rdy <= 1'b0;
      bus.frm_err <= 1'b0;
    end else begin
      pair_st <= pair_nx;
      tmo_cnt <= (pair_st == WAIT_LO && rx_st == R_IDLE && !start) ? tmo_cnt + 32'd1 : '0;
      bus.frm_err <= byte_bad | tmo;
      if (byte_ok && pair_st == WAIT_HI) hi <= rx_sh;
      if (byte_ok && pair_st == WAIT_LO) bus.cmd <= {hi, rx_sh};
      bus.cmd_rdy <= (byte_ok && pair_st == WAIT_LO) ||
                     (bus.cmd_rdy && !bus.clr_cmd_rdy && !(byte_ok && pair_st == WAIT_HI));
    end

  assign tx_tick = tx_cnt == BIT_END;
  assign tx_done = tx_st == T_BUSY && tx_tick && tx_bit == 4'd9;
  assign bus.tx_busy = tx_st == T_BUSY;

  always_comb tx_nx = (tx_st == T_IDLE && bus.send_resp) ? T_BUSY : tx_done ? T_IDLE : tx_st;

  // tx_sh holds the data bits then the stop bit; the start bit is driven straight onto TX
  always_ff @(posedge clk)
    if (rst) begin
      tx_st <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '1;
      bus.TX <= 1'b1;
      bus.resp_sent <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      bus.resp_sent <= tx_done;
      tx_cnt <= (tx_st == T_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_st == T_IDLE && bus.send_resp) begin
        bus.TX <= 1'b0;
        tx_sh <= {1'b1, bus.resp};
        tx_bit <= '0;
      end else if (tx_st == T_BUSY && tx_tick && !tx_done) begin
        bus.TX <= tx_sh[0];
        tx_sh <= {1'b1, tx_sh[8:1]};
        tx_bit <= tx_bit + 1'b1;
      end
    end
endmodule

// File: tb/tb_knight_cmd_link.sv
`timescale 1ns/1ps
// tb_knight_cmd_link: directed UART frames checked every cycle against a frame-level model
module tb_knight_cmd_link;
  localparam int B = 16;
  localparam int H = B / 2;
  localparam int TMO = 400;

  typedef struct {
    int at;
    logic [7:0] data;
    bit good;
  } rx_ev_t;

  logic clk = 0, rst = 1, rx_drv = 1, loop = 0;
  int n_cmp = 0, n_bad = 0, frm_seen = 0, sent_seen = 0;
  int cyc = 0, lo_since = 0, last_start = 0, tx_t0 = 0;
  rx_ev_t rxq[$];
  bit wait_lo = 0, tx_act = 0;
  logic [7:0] hi_m = 0;
  logic [9:0] tx_frame = '1;
  logic [9:0] pat = 10'b1101001010;
  logic [15:0] exp_cmd = 0;
  logic exp_rdy = 0, exp_tx = 1, exp_busy = 0, exp_sent = 0, exp_frm = 0;

  knight_cmd_link_if bus();
  knight_cmd_link #(.BAUD_DIV(B), .BYTE_TMO(32'(TMO))) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.RX = loop ? bus.TX : rx_drv;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // a frame whose line falls after edge `fall` has its stop sample registered
  // after 2 sync stages, 1 edge-detect clock, half a bit and 9 bits
  task automatic note_rx(input logic [7:0] b, input bit good, input int fall);
    rxq.push_back('{fall + 3 + H + 9 * B, b, good});
    last_start = fall + 3;
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    note_rx(b, stop, cyc);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      tick(B);
    end
  endtask

  task automatic idle(input int n);
    rx_drv = 1;
    tick(n);
  endtask

  task automatic send(input logic [7:0] r);
    bus.resp = r;
    bus.send_resp = 1;
    tick(1);
    bus.send_resp = 0;
  endtask

  task automatic wait_tx;
    for (int i = 0; i < 12 * B && bus.tx_busy; i++) tick(1);
    chk("tx_done_wait", 16'(bus.tx_busy), 16'd0);
  endtask

  always @(posedge clk) begin
    bit newhi, set, was;
    rx_ev_t ev;
    int k;
    cyc++;
    if (rst) begin
      rxq.delete();
      wait_lo = 0; tx_act = 0;
      exp_cmd = 0; exp_rdy = 0; exp_tx = 1; exp_busy = 0; exp_sent = 0; exp_frm = 0;
    end else begin
      newhi = 0; set = 0; exp_frm = 0; exp_sent = 0;
      if (rxq.size() > 0 && rxq[0].at == cyc) begin
        ev = rxq.pop_front();
        if (!ev.good) begin exp_frm = 1; wait_lo = 0; end
        else if (!wait_lo) begin hi_m = ev.data; wait_lo = 1; lo_since = cyc; newhi = 1; end
        else begin exp_cmd = {hi_m, ev.data}; wait_lo = 0; set = 1; end
      end else if (wait_lo && cyc - lo_since == TMO &&
                   !(last_start > lo_since && last_start <= cyc)) begin
        exp_frm = 1; wait_lo = 0;
      end
      exp_rdy = set | (exp_rdy & ~bus.clr_cmd_rdy & ~newhi);
      was = tx_act;
      if (tx_act) begin
        k = (cyc - tx_t0) / B;
        if (k >= 10) begin tx_act = 0; exp_sent = 1; exp_tx = 1; end
        else exp_tx = tx_frame[k];
      end
      if (!was && bus.send_resp) begin
        tx_act = 1; tx_t0 = cyc; tx_frame = {1'b1, bus.resp, 1'b0}; exp_tx = 0;
      end
      exp_busy = tx_act;
    end
  end

  always @(negedge clk) begin
    chk("TX", 16'(bus.TX), 16'(exp_tx));
    chk("cmd", bus.cmd, exp_cmd);
    chk("cmd_rdy", 16'(bus.cmd_rdy), 16'(exp_rdy));
    chk("tx_busy", 16'(bus.tx_busy), 16'(exp_busy));
    chk("resp_sent", 16'(bus.resp_sent), 16'(exp_sent));
    chk("frm_err", 16'(bus.frm_err), 16'(exp_frm));
    if (bus.frm_err === 1'b1) frm_seen++;
    if (bus.resp_sent === 1'b1) sent_seen++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int f0, s0;
    bus.clr_cmd_rdy = 0; bus.send_resp = 0; bus.resp = 0;
    tick(3);
    rst = 0;
    chk("rst_TX", 16'(bus.TX), 16'd1);
    chk("rst_cmd", bus.cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
    chk("rst_tx_busy", 16'(bus.tx_busy), 16'd0);
    idle(5);

    rx_byte(8'h2A, 1); rx_byte(8'h5C, 1);
    chk("pair_2A5C", bus.cmd, 16'h2A5C);
    chk("rdy_2A5C", 16'(bus.cmd_rdy), 16'd1);
    bus.clr_cmd_rdy = 1; tick(1); bus.clr_cmd_rdy = 0; tick(1);
    chk("clr_rdy", 16'(bus.cmd_rdy), 16'd0);
    chk("clr_cmd_kept", bus.cmd, 16'h2A5C);

    f0 = frm_seen;
    rx_byte(8'h2A, 1); rx_byte(8'h77, 0); idle(20);
    chk("bad_stop_frm", 16'(frm_seen - f0), 16'd1);
    chk("bad_stop_rdy", 16'(bus.cmd_rdy), 16'd0);
    rx_byte(8'h11, 1); rx_byte(8'h22, 1);
    chk("pair_1122", bus.cmd, 16'h1122);

    f0 = frm_seen;
    rx_byte(8'h2A, 1); idle(TMO + 10);
    chk("tmo_frm", 16'(frm_seen - f0), 16'd1);
    rx_byte(8'h33, 1); rx_byte(8'h44, 1);
    chk("pair_3344", bus.cmd, 16'h3344);

    s0 = sent_seen;
    send(8'hA5);
    tick(H);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tx_bit%0d", k), 16'(bus.TX), 16'(pat[k]));
      if (k == 4) begin bus.resp = 8'h3C; bus.send_resp = 1; end
      tick(1);
      bus.send_resp = 0;
      tick(B - 1);
    end
    chk("resp_sent_once", 16'(sent_seen - s0), 16'd1);
    chk("tx_idle_after", 16'(bus.tx_busy), 16'd0);
    tick(2 * B);
    chk("no_queued_send", 16'(sent_seen - s0), 16'd1);

    fork
      rx_byte(8'h00, 1);
      begin
        send(8'h5A);
        tick(4 * B - 1);
        rst = 1; tick(1); rst = 0;
        chk("mid_rst_TX", 16'(bus.TX), 16'd1);
        chk("mid_rst_busy", 16'(bus.tx_busy), 16'd0);
        chk("mid_rst_cmd", bus.cmd, 16'h0000);
        chk("mid_rst_rdy", 16'(bus.cmd_rdy), 16'd0);
      end
    join
    idle(5);
    rx_byte(8'hFF, 1); rx_byte(8'h00, 1);
    chk("pair_FF00", bus.cmd, 16'hFF00);

    f0 = frm_seen;
    loop = 1;
    tick(5);
    note_rx(8'h0F, 1, cyc + 1); send(8'h0F); wait_tx;
    note_rx(8'hF0, 1, cyc + 1); send(8'hF0); wait_tx;
    tick(5);
    chk("loop_0FF0", bus.cmd, 16'h0FF0);
    chk("loop_no_frm", 16'(frm_seen - f0), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/knight_cmd_link.md
KNIGHT_CMD_LINK -- requirements
Module: knight_cmd_link

Interface
REQ-001 SHALL have parameter: BAUD_DIV, 2604, clocks per UART bit (19200 baud at 50 MHz).
REQ-002 SHALL have parameter: BYTE_TMO, 32'd2_000_000, max clocks between high-byte stop sample and low-byte start edge.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port: clk  in  1  system clock, all logic on posedge.
REQ-005 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port: RX  in  1  asynchronous UART serial in, from the remote.
REQ-007 SHALL have port: TX  out  1  UART serial out, to the remote.
REQ-008 SHALL have port: cmd  out  16  last complete command, high byte received first.
REQ-009 SHALL have port: cmd_rdy  out  1  level, a new cmd is valid.
REQ-010 SHALL have port: clr_cmd_rdy  in  1  pulse, consumer acknowledges cmd.
REQ-011 SHALL have port: resp  in  8  response byte to send.
REQ-012 SHALL have port: send_resp  in  1  pulse, start sending resp.
REQ-013 SHALL have port: tx_busy  out  1  transmit frame in progress.
REQ-014 SHALL have port: resp_sent  out  1  one-cycle pulse, frame complete.
REQ-015 SHALL have port: frm_err  out  1  one-cycle pulse, bad stop bit or byte timeout.

Function
REQ-016 SHALL double-flop RX into the clk domain before any use; the synchronizer presets to 1.
REQ-017 SHALL detect a start condition as a synchronized 1->0 transition while the receiver is idle.
REQ-018 SHALL re-check the start bit at BAUD_DIV/2 clocks; a sample of 1 SHALL abort to idle silently.
REQ-019 SHALL sample 8 data bits LSB first, each BAUD_DIV clocks after the previous sample, then the stop bit.
REQ-020 SHALL treat a stop sample of 0 as a framing error: frm_err pulses, the byte is discarded, and the assembler returns to WAIT_HI.
REQ-021 SHALL run the assembler FSM WAIT_HI -> WAIT_LO on a good byte, latching it into an internal hi buffer.
REQ-022 SHALL, on a good byte in WAIT_LO, load cmd={hi,byte} and set cmd_rdy on the next clock, then return to WAIT_HI.
REQ-023 SHALL hold cmd stable until the next complete pair; a lone high byte SHALL NOT alter cmd.
REQ-024 SHALL clear cmd_rdy on clr_cmd_rdy or on receipt of a new high byte.
REQ-025 SHALL let set win when a cmd_rdy set and clr_cmd_rdy coincide.
REQ-026 SHALL, when BYTE_TMO clocks elapse in WAIT_LO with no start edge, pulse frm_err, drop hi, and go to WAIT_HI.
REQ-027 SHALL hold TX at 1 when idle.
REQ-028 SHALL, when send_resp is seen while tx_busy=0, latch resp and assert tx_busy on the next clock.
REQ-029 SHALL send a frame of 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), each BAUD_DIV clocks wide.
REQ-030 SHALL ignore send_resp while tx_busy=1, with no queueing.
REQ-031 SHALL deassert tx_busy and pulse resp_sent for 1 cycle at the end of the stop bit (10*BAUD_DIV clocks after TX falls).
REQ-032 SHALL run the receiver and transmitter independently, full duplex.
REQ-033 SHALL size the baud counters to ceil(log2(BAUD_DIV+1)) bits and the timeout counter to 32 bits, with no wrap during a bit.

Reset
REQ-034 SHALL, on rst, set TX=1, cmd=16'h0000, cmd_rdy=0, tx_busy=0, resp_sent=0, frm_err=0, and put the FSMs in idle/WAIT_HI.
REQ-035 SHALL, when rst is asserted mid-frame, abort the frame within 1 clock; TX returns high and partial receive data is discarded.
REQ-036 SHALL treat the RX line as idle after rst; a 0 already present needs a fresh 1->0 edge before reception starts.

Verification
REQ-037 SHALL cover: bytes 8'h2A then 8'h5C on RX -> cmd=16'h2A5C, cmd_rdy=1 one clock after the second stop sample; pulse clr_cmd_rdy -> cmd_rdy=0, cmd unchanged.
REQ-038 SHALL cover: 8'h2A, then the second byte with stop bit=0 -> frm_err pulse, cmd_rdy stays 0; then 8'h11, 8'h22 -> cmd=16'h1122.
REQ-039 SHALL cover: 8'h2A, then idle for BYTE_TMO+10 clocks -> frm_err pulse; then 8'h33, 8'h44 -> cmd=16'h3344.
REQ-040 SHALL cover: resp=8'hA5 with send_resp -> TX bits 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing, resp_sent pulse at 10*BAUD_DIV clocks, and a second send_resp issued mid-frame ignored.
REQ-041 SHALL cover: rst asserted 4 bit-times into both an RX and a TX frame -> all outputs at reset values next clock, then 8'hFF, 8'h00 received cleanly -> cmd=16'hFF00.
REQ-042 SHALL cover: loopback TX->RX, two sends of 8'h0F and 8'hF0 -> cmd=16'h0FF0 with no frm_err.
